// File: rtl/mmult_operand_loader.sv
// Serial-to-parallel operand loader feeding the 3x3 matrix multiplier.
// Define MMULT_LOADER_B_COLMAJOR_EN to accept operand B beats column-major.
module mmult_operand_loader #(
  parameter int DATA_W = 18,
  parameter int N      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DATA_W*N*N-1:0]    AI,
  output logic [DATA_W*N*N-1:0]    BI,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err
);

  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] bslot;
  logic          xfer;
  logic          at_end;
  logic          exp_last;

  assign in_ready = (state != FULL);
  assign xfer     = in_valid && in_ready;
  assign at_end   = (idx == LAST);
  assign exp_last = (state == LOAD_B) && at_end;

`ifdef MMULT_LOADER_B_COLMAJOR_EN
  // beat k lands on row (k mod N), column (k div N)
  assign bslot = IW'((int'(idx) % N) * N + int'(idx) / N);
`else
  assign bslot = idx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_A;
      idx       <= '0;
      AI        <= '0;
      BI        <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (xfer && (in_last != exp_last))
        err <= 1'b1;
      unique case (state)
        LOAD_A: begin
          if (xfer) begin
            AI[int'(idx)*DATA_W +: DATA_W] <= in_data;
            if (at_end) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            BI[int'(bslot)*DATA_W +: DATA_W] <= in_data;
            if (at_end) begin
              idx       <= '0;
              state     <= FULL;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
